// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Arbitrates the core's instruction-fetch port and data port onto a single
// 32-bit word memory (separate read/write address, 1-cycle registered read,
// word-only write). One request is granted per cycle; reads pipeline at one
// per cycle. Byte and halfword stores are done as a two-cycle
// read-modify-write. Every accepted request gets exactly one response pulse.
//
// Build option:
//   MEM_ARB_RR_EN  defined   -> round-robin on contention (1-bit last-grant
//                               pointer, reset value favours data)
//                  undefined -> fixed priority, data over fetch
//
// Ports:
//   clk_i, reset_i                     clock, synchronous active-high reset
//   if_req_valid_i/addr_i/ready_o      fetch request handshake
//   if_rsp_valid_o/data_o              fetch response pulse + word
//   d_req_valid_i/addr_i/write_i/
//     size_i/wdata_i/ready_o           data request handshake
//   d_rsp_valid_o/data_o               data response pulse + load word (0 for stores)
//   mem_rd_addr_o, mem_rd_data_i       memory read port (data one cycle later)
//   mem_wr_addr_o/data_o/enable_o      memory write port
// -----------------------------------------------------------------------------
module mem_arbiter (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        if_req_valid_i,
    input  logic [31:0] if_req_addr_i,
    output logic        if_req_ready_o,
    output logic        if_rsp_valid_o,
    output logic [31:0] if_rsp_data_o,
    input  logic        d_req_valid_i,
    input  logic [31:0] d_req_addr_i,
    input  logic        d_req_write_i,
    input  logic [1:0]  d_req_size_i,
    input  logic [31:0] d_req_wdata_i,
    output logic        d_req_ready_o,
    output logic        d_rsp_valid_o,
    output logic [31:0] d_rsp_data_o,
    output logic [31:0] mem_rd_addr_o,
    input  logic [31:0] mem_rd_data_i,
    output logic [31:0] mem_wr_addr_o,
    output logic [31:0] mem_wr_data_o,
    output logic        mem_wr_enable_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_RSP = 2'd1,
        WR_RSP = 2'd2,
        RMW    = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic        owner_fetch_reg, owner_fetch_next;   // who owns the pending read
    logic [31:0] rd_addr_reg, rd_addr_next;           // last issued read address
    logic [31:0] rmw_addr_reg, rmw_addr_next;
    logic [1:0]  rmw_size_reg, rmw_size_next;
    logic [15:0] rmw_wdata_reg, rmw_wdata_next;
    logic        d_win;
    logic        data_first;
    logic [31:0] merged_word;

    // The fetch port is word-only; its low address bits carry no meaning.
    logic unused_if_addr_bits;
    assign unused_if_addr_bits = ^if_req_addr_i[1:0];

`ifdef MEM_ARB_RR_EN
    // 1 = fetch was granted last, so data is favoured next time.
    logic last_fetch_reg, last_fetch_next;
    assign data_first = last_fetch_reg;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_fetch_reg <= 1'b1;
        end else begin
            last_fetch_reg <= last_fetch_next;
        end
    end
`else
    assign data_first = 1'b1;
`endif

    // Read-modify-write merge: each byte lane takes either the latched store
    // data or the old word arriving from memory this cycle.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        logic       lane_hit;
        logic [7:0] lane_src;
        assign lane_hit = (rmw_size_reg == 2'd0) ? (rmw_addr_reg[1:0] == LANE)
                                                 : (rmw_addr_reg[1] == LANE[1]);
        assign lane_src = (rmw_size_reg == 2'd0) ? rmw_wdata_reg[7:0]
                                                 : rmw_wdata_reg[8*(gi%2) +: 8];
        assign merged_word[8*gi +: 8] = lane_hit ? lane_src : mem_rd_data_i[8*gi +: 8];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg       <= IDLE;
            owner_fetch_reg <= 1'b0;
            rd_addr_reg     <= 32'd0;
            rmw_addr_reg    <= 32'd0;
            rmw_size_reg    <= 2'd0;
            rmw_wdata_reg   <= 16'd0;
        end else begin
            state_reg       <= state_next;
            owner_fetch_reg <= owner_fetch_next;
            rd_addr_reg     <= rd_addr_next;
            rmw_addr_reg    <= rmw_addr_next;
            rmw_size_reg    <= rmw_size_next;
            rmw_wdata_reg   <= rmw_wdata_next;
        end
    end

    always_comb begin
        state_next       = IDLE;
        owner_fetch_next = owner_fetch_reg;
        rd_addr_next     = rd_addr_reg;
        rmw_addr_next    = rmw_addr_reg;
        rmw_size_next    = rmw_size_reg;
        rmw_wdata_next   = rmw_wdata_reg;
`ifdef MEM_ARB_RR_EN
        last_fetch_next  = last_fetch_reg;
`endif
        d_win            = 1'b0;
        d_req_ready_o    = 1'b0;
        if_req_ready_o   = 1'b0;
        mem_rd_addr_o    = rd_addr_reg;
        mem_wr_addr_o    = {d_req_addr_i[31:2], 2'b00};
        mem_wr_data_o    = d_req_wdata_i;
        mem_wr_enable_o  = 1'b0;

        if (state_reg == RMW) begin
            // Old word arrives now: write back the merged word, accept nothing.
            mem_wr_enable_o = 1'b1;
            mem_wr_addr_o   = {rmw_addr_reg[31:2], 2'b00};
            mem_wr_data_o   = merged_word;
            state_next      = IDLE;
        end else if (!reset_i) begin
            d_win          = d_req_valid_i && (!if_req_valid_i || data_first);
            d_req_ready_o  = d_win;
            if_req_ready_o = if_req_valid_i && !d_win;

            if (d_win) begin
`ifdef MEM_ARB_RR_EN
                last_fetch_next = 1'b0;
`endif
                owner_fetch_next = 1'b0;
                if (d_req_write_i && d_req_size_i[1]) begin
                    mem_wr_enable_o = 1'b1;
                    state_next      = WR_RSP;
                end else begin
                    rd_addr_next  = {d_req_addr_i[31:2], 2'b00};
                    mem_rd_addr_o = rd_addr_next;
                    if (d_req_write_i) begin
                        rmw_addr_next  = d_req_addr_i;
                        rmw_size_next  = d_req_size_i;
                        rmw_wdata_next = d_req_wdata_i[15:0];
                        state_next     = RMW;
                    end else begin
                        state_next = RD_RSP;
                    end
                end
            end else if (if_req_valid_i) begin
`ifdef MEM_ARB_RR_EN
                last_fetch_next = 1'b1;
`endif
                owner_fetch_next = 1'b1;
                rd_addr_next     = {if_req_addr_i[31:2], 2'b00};
                mem_rd_addr_o    = rd_addr_next;
                state_next       = RD_RSP;
            end
        end

        // A write in flight during reset (notably the RMW write) is suppressed.
        if (reset_i) begin
            mem_wr_enable_o = 1'b0;
        end
    end

    // Responses are decoded from the state flops and the memory's registered
    // read data; gating with reset drops any response pending when reset hits.
    assign if_rsp_valid_o = !reset_i && (state_reg == RD_RSP) && owner_fetch_reg;
    assign if_rsp_data_o  = if_rsp_valid_o ? mem_rd_data_i : 32'd0;
    assign d_rsp_valid_o  = !reset_i && ((state_reg == WR_RSP) || (state_reg == RMW) ||
                                         ((state_reg == RD_RSP) && !owner_fetch_reg));
    assign d_rsp_data_o   = (!reset_i && (state_reg == RD_RSP) && !owner_fetch_reg)
                            ? mem_rd_data_i : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        if_req_valid_i = 1'b0;
    logic [31:0] if_req_addr_i = 32'd0;
    logic        if_req_ready_o;
    logic        if_rsp_valid_o;
    logic [31:0] if_rsp_data_o;
    logic        d_req_valid_i = 1'b0;
    logic [31:0] d_req_addr_i = 32'd0;
    logic        d_req_write_i = 1'b0;
    logic [1:0]  d_req_size_i = 2'd2;
    logic [31:0] d_req_wdata_i = 32'd0;
    logic        d_req_ready_o;
    logic        d_rsp_valid_o;
    logic [31:0] d_rsp_data_o;
    logic [31:0] mem_rd_addr_o;
    logic [31:0] mem_rd_data_i;
    logic [31:0] mem_wr_addr_o;
    logic [31:0] mem_wr_data_o;
    logic        mem_wr_enable_o;

    always #5 clk_i = ~clk_i;

    mem_arbiter dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .if_req_valid_i  (if_req_valid_i),
        .if_req_addr_i   (if_req_addr_i),
        .if_req_ready_o  (if_req_ready_o),
        .if_rsp_valid_o  (if_rsp_valid_o),
        .if_rsp_data_o   (if_rsp_data_o),
        .d_req_valid_i   (d_req_valid_i),
        .d_req_addr_i    (d_req_addr_i),
        .d_req_write_i   (d_req_write_i),
        .d_req_size_i    (d_req_size_i),
        .d_req_wdata_i   (d_req_wdata_i),
        .d_req_ready_o   (d_req_ready_o),
        .d_rsp_valid_o   (d_rsp_valid_o),
        .d_rsp_data_o    (d_rsp_data_o),
        .mem_rd_addr_o   (mem_rd_addr_o),
        .mem_rd_data_i   (mem_rd_data_i),
        .mem_wr_addr_o   (mem_wr_addr_o),
        .mem_wr_data_o   (mem_wr_data_o),
        .mem_wr_enable_o (mem_wr_enable_o)
    );

    function automatic logic [31:0] init_word(input int idx);
        case (idx)
            8'h40:   return 32'hDEADBEEF;   // 0x100
            8'h41:   return 32'h01020304;   // 0x104
            8'h42:   return 32'hA5A5A5A5;   // 0x108
            8'hC0:   return 32'h55555555;   // 0x300
            default: return 32'd0;
        endcase
    endfunction

    // Memory: write applied before a same-edge read.
    logic [31:0] phys_mem [0:255];
    int cyc = 0;
    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (cyc == 0) begin
            for (int i = 0; i < 256; i++) phys_mem[i] <= init_word(i);
            mem_rd_data_i <= 32'd0;
        end else begin
            if (mem_wr_enable_o) phys_mem[mem_wr_addr_o[9:2]] <= mem_wr_data_o;
            mem_rd_data_i <= (mem_wr_enable_o && mem_wr_addr_o[9:2] == mem_rd_addr_o[9:2])
                             ? mem_wr_data_o : phys_mem[mem_rd_addr_o[9:2]];
        end
    end

    // Scoreboard
    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t if_q[$];
    exp_t d_q[$];
    logic [31:0] model_mem [0:255];
    int n_assert = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic push_rsp(input logic is_f, input logic [31:0] d);
        exp_t e;
        e.data = d;
        e.cyc  = cyc + 1;
        if (is_f) if_q.push_back(e);
        else      d_q.push_back(e);
        $display("cyc %0d: accept %s expect rsp data %h at cyc %0d",
                 cyc, is_f ? "fetch" : "data", d, e.cyc);
    endtask

    // Reference effect of a data request accepted at the current sample point.
    task automatic model_d_accept();
        logic [31:0] w;
        int idx;
        idx = int'(d_req_addr_i[9:2]);
        w = model_mem[idx];
        if (!d_req_write_i) begin
            push_rsp(1'b0, w);
        end else begin
            case (d_req_size_i)
                2'd0:    w[8*d_req_addr_i[1:0] +: 8] = d_req_wdata_i[7:0];
                2'd1:    w[16*d_req_addr_i[1] +: 16] = d_req_wdata_i[15:0];
                default: w = d_req_wdata_i;
            endcase
            model_mem[idx] = w;
            push_rsp(1'b0, 32'd0);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_d(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd);
        d_req_valid_i = 1'b1;
        d_req_write_i = wr;
        d_req_size_i  = sz;
        d_req_addr_i  = a;
        d_req_wdata_i = wd;
    endtask

    task automatic wait_d_accept(input string tag, output int acc);
        int n = 0;
        @(negedge clk_i);
        while (!d_req_ready_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check({tag, "_d_accept"}, {31'd0, d_req_ready_o}, 32'd1);
        acc = cyc;
        if (d_req_ready_o) model_d_accept();
        step();
    endtask

    task automatic wait_f_accept(input string tag, output int acc);
        int n = 0;
        @(negedge clk_i);
        while (!if_req_ready_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check({tag, "_f_accept"}, {31'd0, if_req_ready_o}, 32'd1);
        acc = cyc;
        if (if_req_ready_o) push_rsp(1'b1, model_mem[int'(if_req_addr_i[9:2])]);
        step();
    endtask

    // Response monitor: pops expectations on each pulse and flags overdue ones.
    always @(negedge clk_i) begin
        exp_t e;
        if (if_rsp_valid_o) begin
            if (if_q.size() == 0) begin
                check("if_rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = if_q.pop_front();
                $display("cyc %0d: fetch rsp data %h (expected %h)", cyc, if_rsp_data_o, e.data);
                check("if_rsp_data", if_rsp_data_o, e.data);
                check("if_rsp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (d_rsp_valid_o) begin
            if (d_q.size() == 0) begin
                check("d_rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = d_q.pop_front();
                $display("cyc %0d: data rsp data %h (expected %h)", cyc, d_rsp_data_o, e.data);
                check("d_rsp_data", d_rsp_data_o, e.data);
                check("d_rsp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (if_q.size() != 0 && if_q[0].cyc < cyc) begin
            e = if_q.pop_front();
            check("if_rsp_missing", 32'(cyc), 32'(e.cyc));
        end
        if (d_q.size() != 0 && d_q[0].cyc < cyc) begin
            e = d_q.pop_front();
            check("d_rsp_missing", 32'(cyc), 32'(e.cyc));
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int a0, a1, a2;
        logic exp_d;
        for (int i = 0; i < 256; i++) model_mem[i] = init_word(i);

        // Reset with both ports requesting: nothing may be granted or written.
        step(); step();
        if_req_valid_i = 1'b1;
        if_req_addr_i  = 32'h100;
        drive_d(1'b1, 2'd2, 32'h200, 32'h12345678);
        @(negedge clk_i);
        check("rst_if_ready", {31'd0, if_req_ready_o}, 32'd0);
        check("rst_d_ready", {31'd0, d_req_ready_o}, 32'd0);
        check("rst_if_rsp_valid", {31'd0, if_rsp_valid_o}, 32'd0);
        check("rst_d_rsp_valid", {31'd0, d_rsp_valid_o}, 32'd0);
        check("rst_if_rsp_data", if_rsp_data_o, 32'd0);
        check("rst_d_rsp_data", d_rsp_data_o, 32'd0);
        check("rst_wr_enable", {31'd0, mem_wr_enable_o}, 32'd0);
        step();
        if_req_valid_i = 1'b0;
        d_req_valid_i  = 1'b0;
        reset_i        = 1'b0;
        step();

        // Single fetch
        if_req_valid_i = 1'b1;
        if_req_addr_i  = 32'h100;
        wait_f_accept("fetch1", a0);
        if_req_valid_i = 1'b0;
        step(); step();

        // Back-to-back fetches
        if_req_valid_i = 1'b1;
        if_req_addr_i  = 32'h100;
        wait_f_accept("burst0", a0);
        if_req_addr_i  = 32'h104;
        wait_f_accept("burst1", a1);
        if_req_addr_i  = 32'h108;
        wait_f_accept("burst2", a2);
        if_req_valid_i = 1'b0;
        check("burst_gap01", 32'(a1 - a0), 32'd1);
        check("burst_gap12", 32'(a2 - a1), 32'd1);
        step(); step();

        // Word store then load next cycle
        drive_d(1'b1, 2'd2, 32'h200, 32'h11223344);
        wait_d_accept("wstore", a0);
        drive_d(1'b0, 2'd2, 32'h200, 32'd0);
        wait_d_accept("wload", a1);
        d_req_valid_i = 1'b0;
        check("wload_gap", 32'(a1 - a0), 32'd1);
        step();
        check("wstore_mem", phys_mem[8'h80], 32'h11223344);

        // Byte store with a load waiting behind it
        drive_d(1'b1, 2'd0, 32'h203, 32'h000000AB);
        wait_d_accept("bstore", a0);
        drive_d(1'b0, 2'd2, 32'h200, 32'd0);
        @(negedge clk_i);
        check("rmw_d_ready", {31'd0, d_req_ready_o}, 32'd0);
        check("rmw_wr_enable", {31'd0, mem_wr_enable_o}, 32'd1);
        check("rmw_wr_data", mem_wr_data_o, 32'hAB223344);
        check("rmw_wr_addr", mem_wr_addr_o, 32'h200);
        wait_d_accept("bload", a1);
        d_req_valid_i = 1'b0;
        check("bstore_next_accept", 32'(a1 - a0), 32'd2);
        check("bstore_mem", phys_mem[8'h80], 32'hAB223344);

        // Half store over the result
        drive_d(1'b1, 2'd1, 32'h202, 32'h0000CAFE);
        wait_d_accept("hstore", a0);
        drive_d(1'b0, 2'd2, 32'h200, 32'd0);
        wait_d_accept("hload", a1);
        d_req_valid_i = 1'b0;
        step();
        check("hstore_mem", phys_mem[8'h80], 32'hCAFE3344);
        step(); step();

        // Contention for 6 cycles right after reset
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        if_req_valid_i = 1'b1;
        if_req_addr_i  = 32'h104;
        drive_d(1'b0, 2'd2, 32'h100, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
`ifdef MEM_ARB_RR_EN
            exp_d = (i % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            check($sformatf("cont%0d_d_ready", i), {31'd0, d_req_ready_o}, {31'd0, exp_d});
            check($sformatf("cont%0d_if_ready", i), {31'd0, if_req_ready_o}, {31'd0, !exp_d});
            if (exp_d) model_d_accept();
            else       push_rsp(1'b1, model_mem[8'h41]);
            step();
        end
        if_req_valid_i = 1'b0;
        d_req_valid_i  = 1'b0;
        step(); step();

        // Reset during the RMW cycle of a byte store
        drive_d(1'b1, 2'd0, 32'h300, 32'h00000012);
        wait_d_accept("rst_rmw", a0);
        reset_i       = 1'b1;
        d_req_valid_i = 1'b0;
        @(negedge clk_i);
        check("rstrmw_wr_enable", {31'd0, mem_wr_enable_o}, 32'd0);
        check("rstrmw_d_rsp_valid", {31'd0, d_rsp_valid_o}, 32'd0);
        check("rstrmw_d_ready", {31'd0, d_req_ready_o}, 32'd0);
        step();
        d_q.delete();
        if_q.delete();
        model_mem[8'hC0] = 32'h55555555;
        @(negedge clk_i);
        check("rstrmw_d_rsp_data", d_rsp_data_o, 32'd0);
        check("rstrmw_wr_enable2", {31'd0, mem_wr_enable_o}, 32'd0);
        step();
        reset_i = 1'b0;
        step();
        check("rstrmw_mem", phys_mem[8'hC0], 32'h55555555);
        drive_d(1'b0, 2'd2, 32'h300, 32'd0);
        wait_d_accept("rstrmw_load", a1);
        d_req_valid_i = 1'b0;
        step();

        // Byte store with a fetch pending from the start
        if_req_valid_i = 1'b1;
        if_req_addr_i  = 32'h108;
        drive_d(1'b1, 2'd0, 32'h101, 32'h0000005A);
        @(negedge clk_i);
        check("bf_d_ready", {31'd0, d_req_ready_o}, 32'd1);
        check("bf_if_ready0", {31'd0, if_req_ready_o}, 32'd0);
        a0 = cyc;
        if (d_req_ready_o) model_d_accept();
        step();
        d_req_valid_i = 1'b0;
        @(negedge clk_i);
        check("bf_if_ready1", {31'd0, if_req_ready_o}, 32'd0);
        step();
        @(negedge clk_i);
        check("bf_if_ready2", {31'd0, if_req_ready_o}, 32'd1);
        check("bf_fetch_gap", 32'(cyc - a0), 32'd2);
        if (if_req_ready_o) push_rsp(1'b1, model_mem[8'h42]);
        step();
        if_req_valid_i = 1'b0;
        step(); step();
        check("bf_mem", phys_mem[8'h40], 32'hDEAD5AEF);

        // Drain
        repeat (4) step();
        check("if_q_empty", 32'(if_q.size()), 32'd0);
        check("d_q_empty", 32'(d_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
